// File: rtl/cache_refill_arbiter_pkg.sv
// Shared types and geometry for the cache refill arbiter.
//   arb_state_t      : arbiter FSM states
//   DEF_*            : default bus/line geometry used as parameter defaults
//   LINE_BYTES       : bytes per cache line for the default geometry
//   OFFSET_W         : byte-offset bits inside a line for the default geometry
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IC_FILL,
        DC_WB,
        DC_FILL,
        DONE
    } arb_state_t;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int LINE_BYTES     = DEF_LINE_WORDS * 4;
    localparam int OFFSET_W       = $clog2(LINE_BYTES);

endpackage

// File: rtl/cache_refill_arbiter_if.sv
// Bundle of every handshake/bus signal around the refill arbiter.
//   I-cache side : ic_req, ic_addr -> ic_rvalid, ic_rdata, ic_beat, ic_done
//   D-cache side : dc_req, dc_dirty, dc_addr, dc_wb_addr, dc_wdata
//                  -> dc_rvalid, dc_rdata, dc_beat, dc_done
//   Memory side  : mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ack
//   Hazard unit  : cache_busy
// Modports: master = the arbiter, slave = caches + memory + hazard unit.
interface cache_refill_arbiter_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
);
    localparam int BEAT_W = $clog2(LINE_WORDS);

    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_rvalid;
    logic [DATA_W-1:0] ic_rdata;
    logic [BEAT_W-1:0] ic_beat;
    logic              ic_done;

    logic              dc_req;
    logic              dc_dirty;
    logic [ADDR_W-1:0] dc_addr;
    logic [ADDR_W-1:0] dc_wb_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_rvalid;
    logic [DATA_W-1:0] dc_rdata;
    logic [BEAT_W-1:0] dc_beat;
    logic              dc_done;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              cache_busy;

    modport master (
        input  ic_req, ic_addr,
        output ic_rvalid, ic_rdata, ic_beat, ic_done,
        input  dc_req, dc_dirty, dc_addr, dc_wb_addr, dc_wdata,
        output dc_rvalid, dc_rdata, dc_beat, dc_done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output cache_busy
    );

    modport slave (
        output ic_req, ic_addr,
        input  ic_rvalid, ic_rdata, ic_beat, ic_done,
        output dc_req, dc_dirty, dc_addr, dc_wb_addr, dc_wdata,
        input  dc_rvalid, dc_rdata, dc_beat, dc_done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  cache_busy
    );

endinterface

// File: rtl/cache_refill_arbiter.sv
// Shares one backing-memory port between I-cache refills and D-cache
// writeback+refill, moving one word per mem_ack, and raises cache_busy so the
// hazard unit freezes the core while a miss is outstanding.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous, active-low reset
//   bus    : cache_refill_arbiter_if.master (cache, memory and busy signals)
module cache_refill_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cache_refill_arbiter_if.master   bus
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_WORDS * 4 - 1));

    arb_state_t        state_reg;
    logic [BEAT_W-1:0] beat_reg;        // word index of the beat on the memory port
    logic [BEAT_W-1:0] rbeat_reg;       // word index of the word in rdata_reg
    logic              last_grant_dc_reg;
    logic              owner_dc_reg;
    logic [ADDR_W-1:0] line_base_reg;   // line currently on the memory port
    logic [ADDR_W-1:0] fill_base_reg;   // D-cache refill line, held across the writeback
    logic              bubble_reg;      // first DC_FILL cycle after a writeback
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic grant_dc;
    logic grant_ic;
    logic xfer_active;
    logic last_beat;

    // Round-robin: on contention the side that did not win last time gets it.
    assign grant_dc = bus.dc_req & (~bus.ic_req | ~last_grant_dc_reg);
    assign grant_ic = bus.ic_req & ~grant_dc;

    assign xfer_active = (state_reg == IC_FILL) || (state_reg == DC_WB) ||
                         ((state_reg == DC_FILL) && !bubble_reg);
    assign last_beat   = &beat_reg;   // LINE_WORDS is a power of two

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            beat_reg          <= '0;
            rbeat_reg         <= '0;
            last_grant_dc_reg <= 1'b0;
            owner_dc_reg      <= 1'b0;
            line_base_reg     <= '0;
            fill_base_reg     <= '0;
            bubble_reg        <= 1'b0;
            rvalid_reg        <= 1'b0;
            rdata_reg         <= '0;
        end else begin
            rvalid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    beat_reg <= '0;
                    if (grant_dc) begin
                        owner_dc_reg  <= 1'b1;
                        fill_base_reg <= bus.dc_addr & LINE_MASK;
                        if (bus.dc_dirty) begin
                            line_base_reg <= bus.dc_wb_addr & LINE_MASK;
                            state_reg     <= DC_WB;
                        end else begin
                            line_base_reg <= bus.dc_addr & LINE_MASK;
                            state_reg     <= DC_FILL;
                        end
                    end else if (grant_ic) begin
                        owner_dc_reg  <= 1'b0;
                        line_base_reg <= bus.ic_addr & LINE_MASK;
                        state_reg     <= IC_FILL;
                    end
                end

                DC_WB: begin
                    if (bus.mem_ack) begin
                        beat_reg <= beat_reg + 1'b1;
                        if (last_beat) begin
                            // mem_req drops for the bubble cycle before the refill
                            line_base_reg <= fill_base_reg;
                            bubble_reg    <= 1'b1;
                            state_reg     <= DC_FILL;
                        end
                    end
                end

                IC_FILL, DC_FILL: begin
                    if (bubble_reg) begin
                        bubble_reg <= 1'b0;
                    end else if (bus.mem_ack) begin
                        beat_reg   <= beat_reg + 1'b1;
                        rbeat_reg  <= beat_reg;
                        rvalid_reg <= 1'b1;
                        rdata_reg  <= bus.mem_rdata;
                        if (last_beat) begin
                            state_reg <= DONE;
                        end
                    end
                end

                DONE: begin
                    last_grant_dc_reg <= owner_dc_reg;
                    state_reg         <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.mem_req    = xfer_active;
    assign bus.mem_we     = (state_reg == DC_WB);
    assign bus.mem_addr   = line_base_reg | {{(ADDR_W-BEAT_W-2){1'b0}}, beat_reg, 2'b00};
    assign bus.mem_wdata  = (state_reg == DC_WB) ? bus.dc_wdata : '0;

    assign bus.ic_rvalid  = rvalid_reg & ~owner_dc_reg;
    assign bus.ic_rdata   = rdata_reg;
    assign bus.ic_beat    = rbeat_reg;
    assign bus.ic_done    = (state_reg == DONE) & ~owner_dc_reg;

    assign bus.dc_rvalid  = rvalid_reg & owner_dc_reg;
    assign bus.dc_rdata   = rdata_reg;
    // During writeback the D-cache uses dc_beat to select dc_wdata.
    assign bus.dc_beat    = (state_reg == DC_WB) ? beat_reg : rbeat_reg;
    assign bus.dc_done    = (state_reg == DONE) & owner_dc_reg;

    // Combinational so the stall lands in the same cycle as the miss.
    assign bus.cache_busy = bus.ic_req | bus.dc_req | (state_reg != IDLE);

    // A transfer in progress with nobody requesting it is a protocol error.
    req_held_a: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_reg == IC_FILL) || (state_reg == DC_WB) || (state_reg == DC_FILL))
        |-> (bus.ic_req || bus.dc_req));

endmodule
